// File: rtl/display_arbiter.sv
// display_arbiter: shares one display engine between a buffered UART command
// source (A, with error pulses) and a level-request local source (B).
// Error requests show an error pattern for ERR_HOLD cycles and then restore
// the last normal value.
module display_arbiter #(
    parameter int ERR_HOLD = 1000,
    parameter int VAL_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_req,
    input  logic [VAL_W-1:0] a_val,
    input  logic             a_err,
    input  logic             b_req,
    input  logic [VAL_W-1:0] b_val,
    output logic             b_grant,
    input  logic             disp_busy,
    output logic             disp_load,
    output logic [VAL_W-1:0] disp_val,
    output logic             disp_err,
    output logic             owner,
    output logic             a_overrun
);

    localparam int CNT_W = (ERR_HOLD < 2) ? 1 : $clog2(ERR_HOLD + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    state_t             state;
    logic               a_pend;
    logic [VAL_W-1:0]   a_buf;
    logic               err_pend;
    logic [VAL_W-1:0]   sel_val;
    logic               sel_err;
    logic [VAL_W-1:0]   last_val;
    logic [CNT_W-1:0]   hold_cnt;

    logic pick_a;
    logic pick_b;
    logic take_err;
    logic take_a;
    logic take_b;

    // Arbitration in IDLE: error first, then round-robin between A and B
    // (on a tie the source that did not supply the last normal load wins).
    always_comb begin
        pick_a   = a_pend && (!b_req || owner);
        pick_b   = b_req && (!a_pend || !owner);
        take_err = (state == IDLE) && err_pend;
        take_a   = (state == IDLE) && !err_pend && pick_a;
        take_b   = (state == IDLE) && !err_pend && !pick_a && pick_b;
    end

    // The load strobe fires in LOAD as soon as the engine is free; the shown
    // value switches over in that same cycle and is otherwise held.
    assign disp_load = (state == LOAD) && !disp_busy;
    assign disp_val  = disp_load ? sel_val : last_val;
    assign disp_err  = disp_load && sel_err;

    // Pending buffers for source A and for the error request. A new a_req in
    // the cycle the old entry is consumed simply refills the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_pend    <= 1'b0;
            a_buf     <= '0;
            err_pend  <= 1'b0;
            a_overrun <= 1'b0;
        end else begin
            a_overrun <= a_req && a_pend && !take_a;
            if (a_req) begin
                a_pend <= 1'b1;
                a_buf  <= a_val;
            end else if (take_a) begin
                a_pend <= 1'b0;
            end
            if (a_err) begin
                err_pend <= 1'b1;
            end else if (take_err) begin
                err_pend <= 1'b0;
            end
        end
    end

    // Main sequencer: select, load when the engine is free, wait for the
    // engine to finish, and for error loads hold then restore.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel_val  <= '0;
            sel_err  <= 1'b0;
            last_val <= '0;
            hold_cnt <= '0;
            owner    <= 1'b1;
            b_grant  <= 1'b0;
        end else begin
            b_grant <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_err) begin
                        sel_val <= last_val;
                        sel_err <= 1'b1;
                        state   <= LOAD;
                    end else if (take_a) begin
                        sel_val <= a_buf;
                        sel_err <= 1'b0;
                        owner   <= 1'b0;
                        state   <= LOAD;
                    end else if (take_b) begin
                        sel_val <= b_val;
                        sel_err <= 1'b0;
                        owner   <= 1'b1;
                        b_grant <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (!disp_busy) begin
                        last_val <= sel_val;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!disp_busy) begin
                        hold_cnt <= '0;
                        state    <= sel_err ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (hold_cnt == CNT_W'(ERR_HOLD - 1)) begin
                        sel_val <= last_val;
                        sel_err <= 1'b0;
                        state   <= LOAD;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: cycle vector table, directed error/reset
// sequences, and random traffic against a timing-level reference model.
module tb_display_arbiter;

    localparam int VW = 16;
    localparam int EH = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_req, a_err, b_req, disp_busy;
    logic [VW-1:0] a_val, b_val;
    logic          b_grant, disp_load, disp_err, owner, a_overrun;
    logic [VW-1:0] disp_val;

    always #5 clk = ~clk;

    display_arbiter #(.ERR_HOLD(EH), .VAL_W(VW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_val(a_val), .a_err(a_err),
        .b_req(b_req), .b_val(b_val), .b_grant(b_grant),
        .disp_busy(disp_busy), .disp_load(disp_load), .disp_val(disp_val),
        .disp_err(disp_err), .owner(owner), .a_overrun(a_overrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // sampled outputs
    logic          s_load, s_err, s_owner, s_gr, s_ovr;
    logic [VW-1:0] s_val;
    int            cyc = 0;
    int            s_cyc;
    bit            eng_auto = 0;

    task automatic tick();
        @(negedge clk);
        s_load = disp_load; s_val = disp_val; s_err = disp_err;
        s_owner = owner; s_gr = b_grant; s_ovr = a_overrun; s_cyc = cyc;
        @(posedge clk); #1;
        if (eng_auto) disp_busy = s_load;
        a_req = 1'b0;
        a_err = 1'b0;
        cyc++;
    endtask

    task automatic wait_load(input int max_cyc, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!s_load && n < max_cyc);
        check(nm, {31'd0, s_load}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; a_req = 0; a_err = 0; b_req = 0; disp_busy = 0;
        a_val = '0; b_val = '0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit rst; bit ar; logic [VW-1:0] av; bit br; logic [VW-1:0] bv; bit bsy;
        bit e_ld; logic [VW-1:0] e_val; bit e_own; bit e_gr; bit e_ovr;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit ar, input logic [VW-1:0] av,
                       input bit br, input logic [VW-1:0] bv, input bit bsy,
                       input bit ld, input logic [VW-1:0] v, input bit own,
                       input bit gr, input bit ovr);
        vec_t r;
        r.rst = rst; r.ar = ar; r.av = av; r.br = br; r.bv = bv; r.bsy = bsy;
        r.e_ld = ld; r.e_val = v; r.e_own = own; r.e_gr = gr; r.e_ovr = ovr;
        tbl.push_back(r);
    endtask

    // reference model state for random traffic
    bit            m_a_pend, m_err_pend, m_owner, m_load_err, m_gr, m_ovr;
    logic [VW-1:0] m_a_val, m_last, m_load_val;
    int            m_t_idle, m_t_load, m_busy_until, m_k;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_err, t_res, nloads;
        bit e_ld, sel_a, sel_b;

        // ---------------- vector table ----------------
        //   rst ar av      br bv      bsy  ld val     own gr ovr
        add(0, 1, 16'h1234, 0, 16'h0, 0,  0, 16'h0000, 1, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0000, 1, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  1, 16'h1234, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 1,  0, 16'h1234, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h1234, 0, 0, 0);
        add(1, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0000, 1, 0, 0);
        add(0, 1, 16'h0001, 0, 16'h0, 0,  0, 16'h0000, 1, 0, 0);
        add(0, 0, 16'h0,    1, 16'h2, 0,  0, 16'h0000, 1, 0, 0);
        add(0, 0, 16'h0,    1, 16'h2, 0,  1, 16'h0001, 0, 0, 0);
        add(0, 0, 16'h0,    1, 16'h2, 1,  0, 16'h0001, 0, 0, 0);
        add(0, 0, 16'h0,    1, 16'h2, 0,  0, 16'h0001, 0, 0, 0);
        add(0, 0, 16'h0,    1, 16'h2, 0,  0, 16'h0001, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  1, 16'h0002, 1, 1, 0);
        add(0, 0, 16'h0,    0, 16'h0, 1,  0, 16'h0002, 1, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0002, 1, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0002, 1, 0, 0);
        add(0, 1, 16'h0003, 0, 16'h0, 1,  0, 16'h0002, 1, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 1,  0, 16'h0002, 1, 0, 0);
        add(0, 1, 16'h0005, 0, 16'h0, 1,  0, 16'h0002, 0, 0, 0);
        add(0, 1, 16'h0006, 0, 16'h0, 1,  0, 16'h0002, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 1,  0, 16'h0002, 0, 0, 1);
        add(0, 0, 16'h0,    0, 16'h0, 0,  1, 16'h0003, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 1,  0, 16'h0003, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0003, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0003, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  1, 16'h0006, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 1,  0, 16'h0006, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0006, 0, 0, 0);
        add(0, 0, 16'h0,    0, 16'h0, 0,  0, 16'h0006, 0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            reset_n = !tbl[i].rst; a_req = tbl[i].ar; a_val = tbl[i].av;
            b_req = tbl[i].br; b_val = tbl[i].bv; disp_busy = tbl[i].bsy; a_err = 0;
            @(negedge clk);
            check($sformatf("vec%0d_load", i), {31'd0, disp_load}, {31'd0, tbl[i].e_ld});
            check($sformatf("vec%0d_val", i), {16'd0, disp_val}, {16'd0, tbl[i].e_val});
            check($sformatf("vec%0d_err", i), {31'd0, disp_err}, 32'd0);
            check($sformatf("vec%0d_owner", i), {31'd0, owner}, {31'd0, tbl[i].e_own});
            check($sformatf("vec%0d_grant", i), {31'd0, b_grant}, {31'd0, tbl[i].e_gr});
            check($sformatf("vec%0d_ovr", i), {31'd0, a_overrun}, {31'd0, tbl[i].e_ovr});
            @(posedge clk); #1;
        end
        reset_n = 1'b1;

        // ---------------- error load, hold, restore, A during hold ----------------
        do_reset();
        eng_auto = 1;
        a_req = 1; a_val = 16'h0042; tick();
        tick();
        a_err = 1; tick();
        check("err_seq_load42", {31'd0, s_load}, 32'd1);
        check("err_seq_val42", {16'd0, s_val}, 32'h0042);
        a_err = 1; tick();
        wait_load(10, "err_load_seen");
        t_err = s_cyc;
        check("err_load_flag", {31'd0, s_err}, 32'd1);
        check("err_load_val", {16'd0, s_val}, 32'h0042);
        check("err_load_owner", {31'd0, s_owner}, 32'd0);
        tick(); tick(); tick();
        a_req = 1; a_val = 16'h0099; tick();
        wait_load(20, "restore_seen");
        t_res = s_cyc;
        check("restore_time", t_res - t_err, EH + 3);
        check("restore_flag", {31'd0, s_err}, 32'd0);
        check("restore_val", {16'd0, s_val}, 32'h0042);
        wait_load(10, "a99_seen");
        check("a99_time", s_cyc - t_res, 4);
        check("a99_val", {16'd0, s_val}, 32'h0099);
        check("a99_err", {31'd0, s_err}, 32'd0);
        nloads = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_load) nloads++;
        end
        check("second_err_absorbed", nloads, 0);

        // ---------------- reset during WAIT ----------------
        do_reset();
        a_req = 1; a_val = 16'h0077; wait_load(10, "r_load77");
        check("r_val77", {16'd0, s_val}, 32'h0077);
        reset_n = 0; a_req = 1; a_val = 16'h0055; tick();
        check("rst_load", {31'd0, s_load}, 32'd0);
        check("rst_val", {16'd0, s_val}, 32'd0);
        check("rst_err", {31'd0, s_err}, 32'd0);
        check("rst_owner", {31'd0, s_owner}, 32'd1);
        check("rst_grant", {31'd0, s_gr}, 32'd0);
        check("rst_ovr", {31'd0, s_ovr}, 32'd0);
        reset_n = 1;
        nloads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_load) nloads++;
        end
        check("rst_no_load", nloads, 0);
        a_req = 1; a_val = 16'h0011; wait_load(10, "post_rst_load");
        check("post_rst_val", {16'd0, s_val}, 32'h0011);
        eng_auto = 0;
        tick(); tick(); tick();

        // ---------------- random traffic vs model ----------------
        do_reset();
        m_a_pend = 0; m_err_pend = 0; m_owner = 1; m_load_err = 0; m_gr = 0; m_ovr = 0;
        m_a_val = '0; m_last = '0; m_load_val = '0;
        m_t_idle = 0; m_t_load = -1; m_busy_until = -1; m_k = 1;
        for (int c = 0; c < 3000; c++) begin
            a_req = ($urandom_range(0, 3) == 0);
            a_val = 16'($urandom);
            a_err = ($urandom_range(0, 59) == 0);
            if (!b_req && $urandom_range(0, 5) == 0) begin
                b_req = 1; b_val = 16'($urandom);
            end
            disp_busy = (c <= m_busy_until);
            @(negedge clk);
            e_ld = (c == m_t_load);
            check("rnd_load", {31'd0, disp_load}, {31'd0, e_ld});
            check("rnd_val", {16'd0, disp_val}, {16'd0, e_ld ? m_load_val : m_last});
            check("rnd_err", {31'd0, disp_err}, {31'd0, e_ld && m_load_err});
            check("rnd_owner", {31'd0, owner}, {31'd0, m_owner});
            check("rnd_grant", {31'd0, b_grant}, {31'd0, m_gr});
            check("rnd_ovr", {31'd0, a_overrun}, {31'd0, m_ovr});
            // model update for this clock edge
            m_gr = 0; m_ovr = 0; sel_a = 0; sel_b = 0;
            if (e_ld) begin
                m_busy_until = c + m_k;
                if (m_load_err) begin
                    m_t_load   = c + m_k + EH + 2;
                    m_load_err = 0;
                    m_load_val = m_last;
                    m_k        = $urandom_range(1, 3);
                end else begin
                    m_last   = m_load_val;
                    m_t_idle = c + m_k + 2;
                end
            end else if (c == m_t_idle) begin
                if (m_err_pend) begin
                    m_err_pend = 0; m_load_err = 1; m_load_val = m_last;
                end else if (m_a_pend && (!b_req || m_owner)) begin
                    sel_a = 1; m_load_err = 0; m_load_val = m_a_val; m_owner = 0;
                end else if (b_req) begin
                    sel_b = 1; m_load_err = 0; m_load_val = b_val; m_owner = 1; m_gr = 1;
                end
                if (m_load_err || sel_a || sel_b) begin
                    m_t_load = c + 1; m_t_idle = -1; m_k = $urandom_range(1, 3);
                end else begin
                    m_t_idle = c + 1;
                end
            end
            if (a_err) m_err_pend = 1;
            if (a_req) begin
                if (m_a_pend && !sel_a) m_ovr = 1;
                m_a_pend = 1; m_a_val = a_val;
            end else if (sel_a) begin
                m_a_pend = 0;
            end
            @(posedge clk); #1;
            if (sel_b) b_req = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
